// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - default oversample ratio
//   - sample indices used for the 3-point majority vote
//   - maj3(): majority-of-three helper
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int VOTE_S0 = 3;
  localparam int VOTE_S1 = 4;
  localparam int VOTE_S2 = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running prescaler that produces the oversample tick.
//   A 16-bit down-counter; tick_o is high for one clk whenever the count is 0,
//   and the counter then reloads so that the tick period is
//   max(preescalar_data_rate,1) clk. A new prescaler value is picked up at
//   the next reload. Shared by the RX and TX sides.
// Ports:
//   clk                   in   system clock
//   rst                   in   asynchronous reset, active-low
//   preescalar_data_rate  in   clk cycles per tick (0 behaves as 1)
//   tick_o                out  one-clk sample tick
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] preescalar_data_rate,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload;

  always_comb begin
    reload = (preescalar_data_rate == 16'd0) ? 16'd1 : preescalar_data_rate;
    tick_o = (cnt_q == 16'd0);
    // Reloading with period-1 makes the count 0 exactly once per period.
    cnt_d  = tick_o ? (reload - 16'd1) : (cnt_q - 16'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART receive front-end.
//   Synchronises rtx, oversamples it with the prescaler tick, majority-votes
//   each bit over samples 3/4/5, deserialises LSB first, and presents each
//   byte on a one-entry valid/ready holding register with per-byte flags.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronised line
//   START  | checking the start bit (voted 1 = glitch, back to IDLE)
//   DATA   | shifting in DATA_WIDTH bits
//   PARITY | checking even parity (only with UART_RX_PARITY_EN)
//   STOP   | stop bit voted at sample 5, byte delivered, back to IDLE
//
// Configuration macro: UART_RX_PARITY_EN adds an even-parity bit to the
//   frame and drives parity_err_o; without it parity_err_o is tied 0.
// Ports:
//   clk, rst (async, active-low), rtx (serial in, idle high),
//   preescalar_data_rate (clk per sample tick), ready_i (consumer accepts),
//   data_o / valid_o / frame_err_o / parity_err_o (holding register),
//   overrun_o (1-clk pulse: byte dropped), busy_o (FSM not IDLE)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rtx,
  input  logic [15:0]           preescalar_data_rate,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(VOTE_S0);
  localparam logic [SW-1:0] S_V1   = SW'(VOTE_S1);
  localparam logic [SW-1:0] S_V2   = SW'(VOTE_S2);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);

  logic                  tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  rx_s;
  logic                  rx_prev_q;
  logic [SW-1:0]         s_q, s_d;
  logic [2:0]            vote_q, vote_d;
  logic [2:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  bit_mid;
  logic                  stop_vote;
  logic                  deliver;
  logic                  load;
  logic                  consume;

  uart_baud_tick u_baud_tick (
    .clk                  (clk),
    .rst                  (rst),
    .preescalar_data_rate (preescalar_data_rate),
    .tick_o               (tick)
  );

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rtx};
      rx_prev_q <= rx_s;
    end
  end

  // Vote used at the end of a bit; the stop bit is decided at sample 5
  // using the live third sample so the FSM can leave half a bit early.
  assign bit_mid   = maj3(vote_q[0], vote_q[1], vote_q[2]);
  assign stop_vote = maj3(vote_q[0], vote_q[1], rx_s);
  assign deliver   = tick && (state_q == ST_STOP) && (s_q == S_V2);

  always_comb begin
    s_d    = s_q;
    vote_d = vote_q;
    if (state_q == ST_IDLE) begin
      s_d = '0;
    end else if (tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
      if (s_q == S_V0) vote_d[0] = rx_s;
      if (s_q == S_V1) vote_d[1] = rx_s;
      if (s_q == S_V2) vote_d[2] = rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_int_q, par_int_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_int_d = par_int_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (tick && s_q == S_LAST) state_d = bit_mid ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick && s_q == S_LAST) begin
          shift_d[idx_q] = bit_mid;
          if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick && s_q == S_LAST) begin
          par_int_d = bit_mid ^ (^shift_q);
          state_d   = ST_STOP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (deliver) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: a load on the same edge as a consume keeps valid high.
  assign load    = deliver && (!valid_q || ready_i);
  assign consume = valid_q && ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = deliver && valid_q && !ready_i;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~stop_vote;
`ifdef UART_RX_PARITY_EN
      perr_d  = par_int_q;
`endif
    end else if (consume) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q     <= '0;
      vote_q  <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_int_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      s_q     <= s_d;
      vote_q  <= vote_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_int_q <= par_int_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed + randomized bench for uart_rx_sampler.
//   Frames are driven at bit level; expected bytes/flags come from the
//   frame contents (data, stop level, parity bit). Honours UART_RX_PARITY_EN.
module tb_uart_rx_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtx;
  logic [15:0] preescalar_data_rate;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_clk  = 16;

  logic [9:0] rxq[$];
  int         ovr_cnt   = 0;
  int         valid_cnt = 0;
  logic       busy_seen = 1'b0;

  uart_rx_sampler dut (
    .clk                  (clk),
    .rst                  (rst),
    .rtx                  (rtx),
    .preescalar_data_rate (preescalar_data_rate),
    .ready_i              (ready_i),
    .data_o               (data_o),
    .valid_o              (valid_o),
    .frame_err_o          (frame_err_o),
    .parity_err_o         (parity_err_o),
    .overrun_o            (overrun_o),
    .busy_o               (busy_o)
  );

  always #5 clk = ~clk;

  // Record consumed bytes and count pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o && ready_i) rxq.push_back({parity_err_o, frame_err_o, data_o});
      if (overrun_o) ovr_cnt++;
      if (valid_o) valid_cnt++;
      if (busy_o) busy_seen = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rtx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rtx = b;
    repeat (bit_clk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rtx = 1'b1;
`endif
    drive_bit(stop);
    rtx = 1'b1;
  endtask

  function automatic logic [9:0] model(input logic [7:0] b, input logic stop, input logic par);
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = (par != (^b));
`else
    pe = 1'b0 & par;
`endif
    return {pe, ~stop, b};
  endfunction

  task automatic expect_frame(input string tag, input logic [7:0] b, input logic stop,
                              input logic par);
    logic [9:0] got, exp;
    for (int i = 0; i < 400 && rxq.size() == 0; i++) @(negedge clk);
    chk({tag, "_recv"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) begin
      got = rxq.pop_front();
      exp = model(b, stop, par);
      chk({tag, "_data"}, 32'(got[7:0]), 32'(exp[7:0]));
      chk({tag, "_ferr"}, 32'(got[8]), 32'(exp[8]));
      chk({tag, "_perr"}, 32'(got[9]), 32'(exp[9]));
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs, rp;
    int         pv;

    rst = 1'b0; rtx = 1'b1; ready_i = 1'b1; preescalar_data_rate = 16'd2;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    chk("rst_perr", 32'(parity_err_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b1;
    idle(20);

    // Clean frame: one-cycle valid, no overrun.
    valid_cnt = 0; ovr_cnt = 0;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(16);
    expect_frame("a5", 8'hA5, 1'b1, ^8'hA5);
    chk("a5_valid_cycles", 32'(valid_cnt), 32'd1);
    chk("a5_ovr", 32'(ovr_cnt), 32'd0);

    // Start-bit glitch.
    idle(16);
    busy_seen = 1'b0; valid_cnt = 0;
    rtx = 1'b0;
    repeat (6) @(negedge clk);
    rtx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_idle", 32'(busy_o), 32'd0);
    chk("glitch_no_valid", 32'(valid_cnt), 32'd0);
    chk("glitch_no_byte", 32'(rxq.size()), 32'd0);

    // Bad stop then good stop.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(16);
    expect_frame("3c_badstop", 8'h3C, 1'b0, ^8'h3C);
    send_frame(8'h01, 1'b1, ^8'h01);
    idle(16);
    expect_frame("01_goodstop", 8'h01, 1'b1, 1'b1);

    // Randomized frames, prescaler and gaps.
    for (int k = 0; k < 8; k++) begin
      pv = $urandom_range(0, 3);
      preescalar_data_rate = 16'(pv);
      bit_clk = 8 * ((pv == 0) ? 1 : pv);
      idle(2 * bit_clk);
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      send_frame(rb, rs, rp);
      idle(bit_clk * $urandom_range(1, 3));
      expect_frame("rand", rb, rs, rp);
    end
    preescalar_data_rate = 16'd2;
    bit_clk = 16;
    idle(32);

    // Overrun: back-to-back frames with the consumer stalled.
    ready_i = 1'b0; ovr_cnt = 0; rxq.delete();
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(16);
    chk("ovr_valid", 32'(valid_o), 32'd1);
    chk("ovr_data_held", 32'(data_o), 32'h11);
    chk("ovr_ferr", 32'(frame_err_o), 32'd0);
    chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
    ready_i = 1'b1;
    @(negedge clk);
    chk("ovr_valid_drop", 32'(valid_o), 32'd0);
    idle(8);
    rxq.delete();

    // Async reset in the middle of a frame.
    ready_i = 1'b0;
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(16);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    drive_bit(1'b0);
    rtx = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b1; ready_i = 1'b1; rxq.delete();
    idle(20);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(16);
    expect_frame("5a_after_rst", 8'h5A, 1'b1, ^8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(16);
    expect_frame("par_bad", 8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(16);
    expect_frame("par_good", 8'h07, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
